// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, functs, ALU codes.
// The BNEEX state exists only when MC_BNE_EN is defined.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
`ifdef MC_BNE_EN
        , S_BNEEX = 4'd12
`endif
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] AC_AND = 3'b000;
    localparam logic [2:0] AC_OR  = 3'b001;
    localparam logic [2:0] AC_ADD = 3'b010;
    localparam logic [2:0] AC_SUB = 3'b110;
    localparam logic [2:0] AC_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's aluop plus the R-type funct field into an ALU operation.
module mc_aludec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = AC_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = AC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = AC_ADD;
                    FN_SUB:  alucontrol = AC_SUB;
                    FN_AND:  alucontrol = AC_AND;
                    FN_OR:   alucontrol = AC_OR;
                    FN_SLT:  alucontrol = AC_SLT;
                    default: alucontrol = AC_AND;
                endcase
            end
            default: alucontrol = AC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-style Moore controller; the state register is the only storage.
// Optional MC_BNE_EN adds a BNEEX state for bne.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_e     state_q, state_d;
    logic       pcwrite, branch;
    logic [1:0] aluop;
`ifdef MC_BNE_EN
    logic       bne;
`endif

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = S_BNEEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            // op is re-examined here; the IR holds it stable across the instruction
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = ALUOP_ADD;
`ifdef MC_BNE_EN
        bne      = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_BNE_EN
            S_BNEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                bne     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifdef MC_BNE_EN
    assign pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
    assign pcen = pcwrite | (branch & zero);
`endif

    assign state = state_q;

    mc_aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction runs plus random op/funct/zero/reset,
// checked against a step-count model built from per-opcode state sequences.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_chk  = 0;
    int n_pass = 0;
    int step   = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state(state)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step=%0d op=%b: got %h expected %h", tag, step, op, got, exp);
    endtask

    // Cycles per instruction, straight from the opcode.
    function automatic int cpi(input logic [5:0] o);
        case (o)
            OP_LW:                      return 5;
            OP_SW, OP_RTYPE, OP_ADDI:   return 4;
            OP_BEQ, OP_J:               return 3;
`ifdef MC_BNE_EN
            OP_BNE:                     return 3;
`endif
            default:                    return 2;
        endcase
    endfunction

    function automatic logic [3:0] state_at(input logic [5:0] o, input int s);
        if (s == 0) return S_FETCH;
        if (s == 1) return S_DECODE;
        case (o)
            OP_LW:    return (s == 2) ? S_MEMADR : (s == 3) ? S_MEMRD : S_MEMWB;
            OP_SW:    return (s == 2) ? S_MEMADR : S_MEMWR;
            OP_RTYPE: return (s == 2) ? S_RTYPEEX : S_RTYPEWB;
            OP_ADDI:  return (s == 2) ? S_ADDIEX : S_ADDIWB;
            OP_BEQ:   return S_BEQEX;
            OP_J:     return S_JEX;
`ifdef MC_BNE_EN
            OP_BNE:   return S_BNEEX;
`endif
            default:  return 4'hF;
        endcase
    endfunction

    // {pcwrite,branch,bne,memwrite,irwrite,regwrite,iord,alusrca,regdst,memtoreg,alusrcb,pcsrc}
    function automatic logic [13:0] ctrl_of(input logic [3:0] st);
        case (st)
            S_FETCH:            return 14'b1_0_0_0_1_0_0_0_0_0_01_00;
            S_DECODE:           return 14'b0_0_0_0_0_0_0_0_0_0_11_00;
            S_MEMADR, S_ADDIEX: return 14'b0_0_0_0_0_0_0_1_0_0_10_00;
            S_MEMRD:            return 14'b0_0_0_0_0_0_1_0_0_0_00_00;
            S_MEMWB:            return 14'b0_0_0_0_0_1_0_0_0_1_00_00;
            S_MEMWR:            return 14'b0_0_0_1_0_0_1_0_0_0_00_00;
            S_RTYPEEX:          return 14'b0_0_0_0_0_0_0_1_0_0_00_00;
            S_RTYPEWB:          return 14'b0_0_0_0_0_1_0_0_1_0_00_00;
            S_BEQEX:            return 14'b0_1_0_0_0_0_0_1_0_0_00_01;
            S_ADDIWB:           return 14'b0_0_0_0_0_1_0_0_0_0_00_00;
            S_JEX:              return 14'b1_0_0_0_0_0_0_0_0_0_00_10;
            4'd12:              return 14'b0_0_1_0_0_0_0_1_0_0_00_01;
            default:            return 14'b0;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] st, input logic [5:0] f);
        if (st == S_BEQEX || st == 4'd12) return 3'b110;
        if (st != S_RTYPEEX) return 3'b010;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    task automatic cycle(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        logic [3:0]  es;
        logic [13:0] c;
        op = o; funct = f; zero = z; reset = r;
        #1;
        es = state_at(o, step);
        c  = ctrl_of(es);
        chk("state", {12'd0, state}, {12'd0, es});
        chk("pcen", {15'd0, pcen}, {15'd0, c[13] | (c[12] & z) | (c[11] & ~z)});
        chk("strobes", {13'd0, memwrite, irwrite, regwrite}, {13'd0, c[10:8]});
        chk("muxes", {8'd0, iord, alusrca, regdst, memtoreg, alusrcb, pcsrc}, {8'd0, c[7:0]});
        chk("alucontrol", {13'd0, alucontrol}, {13'd0, alu_of(es, f)});
        @(posedge clk);
        if (r) step = 0;
        else begin
            step++;
            if (step >= cpi(o)) step = 0;
        end
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        do cycle(o, f, z, 1'b0); while (step != 0);
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 8))
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_RTYPE;
            3: return OP_BEQ;
            4: return OP_ADDI;
            5: return OP_J;
            6: return OP_BNE;
            7: return 6'b111111;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] rand_funct();
        case ($urandom_range(0, 5))
            0: return FN_ADD;
            1: return FN_SUB;
            2: return FN_AND;
            3: return FN_OR;
            4: return FN_SLT;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] cur_op;
        op = OP_LW; funct = FN_ADD; zero = 1'b0; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        step = 0;
        cycle(OP_LW, FN_ADD, 1'b0, 1'b1);

        // reset held two cycles while an lw sits in MEMRD
        cycle(OP_LW, FN_ADD, 1'b0, 1'b0);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b0);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b0);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b1);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b1);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b0);
        cycle(OP_LW, FN_ADD, 1'b0, 1'b0);
        while (step != 0) cycle(OP_LW, FN_ADD, 1'b0, 1'b0);

        run_instr(OP_LW, FN_ADD, 1'b1);
        run_instr(OP_SW, FN_SUB, 1'b0);
        run_instr(OP_BEQ, FN_ADD, 1'b1);
        run_instr(OP_BEQ, FN_ADD, 1'b0);
        run_instr(OP_RTYPE, FN_SLT, 1'b0);
        run_instr(OP_RTYPE, FN_SUB, 1'b1);
        run_instr(OP_RTYPE, 6'b111000, 1'b0);
        run_instr(6'b111111, FN_ADD, 1'b0);
        run_instr(OP_ADDI, FN_OR, 1'b1);
        run_instr(OP_J, FN_ADD, 1'b0);
        run_instr(OP_BNE, FN_ADD, 1'b0);
        run_instr(OP_BNE, FN_ADD, 1'b1);

        cur_op = OP_LW;
        for (int i = 0; i < 2000; i++) begin
            if (step == 0) cur_op = rand_op();
            cycle(cur_op, rand_funct(), 1'($urandom), ($urandom_range(0, 49) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 Reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 op  in  6  instruction opcode from the instruction register.
REQ-006 funct  in  6  instruction function field.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 pcen  out  1  PC register enable.
REQ-009 memwrite, irwrite, regwrite  out  1 each  memory, IR and regfile write strobes.
REQ-010 iord, alusrca, regdst, memtoreg  out  1 each  datapath mux selects.
REQ-011 alusrcb, pcsrc  out  2 each  ALU-B and next-PC mux selects.
REQ-012 alucontrol  out  3  ALU operation.
REQ-013 state  out  4  current FSM state, for debug and bench observation.

Function
REQ-014 The FSM SHALL be Moore, with the states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB and JEX.
REQ-015 Transitions:
- FETCH->DECODE.
- DECODE->MEMADR on lw (100011) or sw (101011).
- DECODE->RTYPEEX on 000000, BEQEX on 000100, ADDIEX on 001000, JEX on 000010.
- DECODE->FETCH on any other opcode.
REQ-016 Further transitions:
- MEMADR->MEMRD on lw, MEMWR on sw.
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, ADDIWB, BEQEX and JEX -> FETCH.
REQ-017 Output values per state; any signal not listed is 0.
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEX: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, aluop=10.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-018 pcen SHALL equal pcwrite | (branch & zero), combinationally from the current state and zero.
REQ-019 Cycles per instruction: lw 5; sw, R-type and addi 4; beq and j 3.
REQ-020 ALU control mapping:
- aluop 00 -> alucontrol 010 (add); aluop 01 -> 110 (sub).
- aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct -> 000.
REQ-021 The state register SHALL be the only storage; all other outputs SHALL be glitch-free decodes of the state register plus op, funct and zero.

Reset
REQ-022 While reset=1 at a rising edge, the state SHALL become FETCH, including mid-instruction; no partially executed instruction resumes.
REQ-023 During and after reset, the outputs SHALL carry FETCH values; the PC reset in the datapath dominates pcen.

Configuration
REQ-024 Macro MC_BNE_EN, when defined:
- adds state BNEEX, reached from DECODE on op 000101.
- BNEEX outputs equal BEQEX except branch=0 and bne=1.
- pcen |= bne & ~zero.
- BNEEX -> FETCH.
REQ-025 Without MC_BNE_EN, op 000101 SHALL be treated as illegal (DECODE->FETCH) and BNEEX SHALL NOT exist.

Structure
REQ-026 Package mc_ctrl_pkg SHALL hold:
- the state enum (4-bit encoding; FETCH=0, BNEEX=12);
- opcode and funct constants;
- aluop and alucontrol constants.
REQ-027 The ALU decode SHALL be the sub-module mc_aludec (inputs funct and aluop, output alucontrol); the FSM and its output decode stay in mc_controller.

Verification
REQ-028 Reset held 2 cycles mid-lw (state MEMRD) -> state=FETCH on the first reset edge; after release, states FETCH, DECODE follow.
REQ-029 op=100011 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite=1 and memtoreg=1 only in MEMWB; iord=1 in MEMRD.
REQ-030 op=101011 -> memwrite=1 for exactly one cycle (MEMWR), then FETCH.
REQ-031 op=000100 with zero=1 -> pcen=1 in BEQEX; with zero=0 -> pcen=0 in BEQEX.
REQ-032 op=000000 with funct=101010 -> alucontrol=111 in RTYPEEX; funct=100010 -> 110.
REQ-033 op=111111 -> DECODE->FETCH with no write strobe asserted; with MC_BNE_EN, op=000101 and zero=0 -> pcen=1 in BNEEX.
